// File: rtl/onewire_pkg.sv
// Shared state encoding, default slot timing and tick-counter width for the 1-Wire initiator.
package onewire_pkg;

    localparam int TICK_W            = 9;

    localparam int LOW1_TICKS_DEF    = 5;
    localparam int LOW0_TICKS_DEF    = 50;
    localparam int SLOT_TICKS_DEF    = 55;
    localparam int REC_TICKS_DEF     = 2;
    localparam int RST_LOW_TICKS_DEF = 400;
    localparam int RST_REL_TICKS_DEF = 400;
    localparam int PRES_TICKS_DEF    = 55;
    localparam int DRAIN_CYCLES_DEF  = 80;

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_RST_LOW,
        S_RST_REL,
        S_SLOT_LOW,
        S_SLOT_REL,
        S_RECOVER
    } ow_state_t;

    // States that consume timer ticks.
    function automatic logic uses_timer(input ow_state_t s);
        return !((s == S_DRAIN) || (s == S_IDLE));
    endfunction

    function automatic logic drives_low(input ow_state_t s);
        return (s == S_RST_LOW) || (s == S_SLOT_LOW);
    endfunction

endpackage

// File: rtl/onewire_tick_timer.sv
// Requesting side of the external 1us delay-timer handshake; counts completed ticks.
module onewire_tick_timer
    import onewire_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              clear,
    input  logic              us_finish,
    output logic              us_start,
    output logic              tick,
    output logic [TICK_W-1:0] ticks
);

    logic outstanding;
    logic issue;

    // A finish only counts when a request is in flight; a new request may be
    // launched in the same cycle that the previous one completes.
    always_comb begin
        tick  = us_finish & outstanding;
        issue = go & (~outstanding | tick);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            us_start    <= 1'b0;
            outstanding <= 1'b0;
            ticks       <= '0;
        end else begin
            us_start <= issue;
            if (issue) begin
                outstanding <= 1'b1;
            end else if (tick) begin
                outstanding <= 1'b0;
            end
            if (clear) begin
                ticks <= '0;
            end else if (tick) begin
                ticks <= ticks + 1'b1;
            end
        end
    end

endmodule

// File: rtl/onewire_master_tx.sv
// 1-Wire initiator: reset/presence sequence or LSB-first byte write, timed by external ticks.
module onewire_master_tx
    import onewire_pkg::*;
#(
    parameter int LOW1_TICKS    = LOW1_TICKS_DEF,
    parameter int LOW0_TICKS    = LOW0_TICKS_DEF,
    parameter int SLOT_TICKS    = SLOT_TICKS_DEF,
    parameter int REC_TICKS     = REC_TICKS_DEF,
    parameter int RST_LOW_TICKS = RST_LOW_TICKS_DEF,
    parameter int RST_REL_TICKS = RST_REL_TICKS_DEF,
    parameter int PRES_TICKS    = PRES_TICKS_DEF,
    parameter int DRAIN_CYCLES  = DRAIN_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_reset,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic       presence,
    output logic       dq_oe,
    input  logic       dq_in,
    output logic       us_start,
    input  logic       us_finish,
    output logic [2:0] dbg_state
);

    localparam logic [TICK_W-1:0] LOW1_LAST    = TICK_W'(LOW1_TICKS - 1);
    localparam logic [TICK_W-1:0] LOW0_LAST    = TICK_W'(LOW0_TICKS - 1);
    localparam logic [TICK_W-1:0] SLOT_LAST    = TICK_W'(SLOT_TICKS - 1);
    localparam logic [TICK_W-1:0] REC_LAST     = TICK_W'(REC_TICKS - 1);
    localparam logic [TICK_W-1:0] RST_LOW_LAST = TICK_W'(RST_LOW_TICKS - 1);
    localparam logic [TICK_W-1:0] RST_REL_LAST = TICK_W'(RST_REL_TICKS - 1);
    localparam logic [TICK_W-1:0] PRES_LAST    = TICK_W'(PRES_TICKS - 1);
    localparam logic [7:0]        DRAIN_LAST   = 8'(DRAIN_CYCLES - 1);

    ow_state_t         state, state_n;
    logic [7:0]        drain_cnt;
    logic [7:0]        data_q;
    logic [2:0]        bit_idx;
    logic              accept;
    logic              go, clear, tick;
    logic [TICK_W-1:0] ticks;
    logic [TICK_W-1:0] low_last;

    // Command handshake: a command transfers on any cycle where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE, so a request made
    // while busy is simply not taken.
    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign dbg_state = state;

    onewire_tick_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .clear     (clear),
        .us_finish (us_finish),
        .us_start  (us_start),
        .tick      (tick),
        .ticks     (ticks)
    );

    always_comb begin
        state_n  = state;
        low_last = data_q[bit_idx] ? LOW1_LAST : LOW0_LAST;
        case (state)
            S_DRAIN:    if (drain_cnt == DRAIN_LAST) state_n = S_IDLE;
            S_IDLE:     if (accept) state_n = cmd_reset ? S_RST_LOW : S_SLOT_LOW;
            S_RST_LOW:  if (tick && ticks == RST_LOW_LAST) state_n = S_RST_REL;
            S_RST_REL:  if (tick && ticks == RST_REL_LAST) state_n = S_IDLE;
            S_SLOT_LOW: if (tick && ticks == low_last) state_n = S_SLOT_REL;
            S_SLOT_REL: if (tick && ticks == SLOT_LAST) state_n = S_RECOVER;
            S_RECOVER: begin
                if (tick && ticks == REC_LAST) begin
                    state_n = (bit_idx == 3'd7) ? S_IDLE : S_SLOT_LOW;
                end
            end
            default:    state_n = S_DRAIN;
        endcase
        // Request the next tick whenever the state we are heading into is timed.
        go    = uses_timer(state_n);
        // The slot's release phase keeps counting from the start of its low phase.
        clear = (state_n != state) && (state != S_SLOT_LOW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
            data_q    <= '0;
            bit_idx   <= '0;
            done      <= 1'b0;
            presence  <= 1'b0;
            dq_oe     <= 1'b0;
        end else begin
            state <= state_n;
            dq_oe <= drives_low(state_n);
            done  <= (state_n == S_IDLE) && uses_timer(state);
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
            if (accept) begin
                data_q  <= cmd_data;
                bit_idx <= '0;
            end else if (state == S_RECOVER && state_n == S_SLOT_LOW) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == S_RST_REL && tick && ticks == PRES_LAST) begin
                presence <= ~dq_in;
            end
        end
    end

endmodule

// File: tb/tb_onewire_master_tx.sv
// Bench for onewire_master_tx: delay-timer responder, pulled-up DQ with optional slave, scoreboard.
module tb_onewire_master_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_reset;
    logic [7:0] cmd_data;
    logic       done;
    logic       presence;
    logic       dq_oe;
    logic       dq_in;
    logic       us_start;
    logic       us_finish;
    logic [2:0] dbg_state;
    logic       slave_pull;

    always #10 clk = ~clk;

    // Open-drain bus with pull-up: low if the master or the slave pulls.
    assign dq_in = ~dq_oe & ~slave_pull;

    onewire_master_tx dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_reset (cmd_reset),
        .cmd_data  (cmd_data),
        .done      (done),
        .presence  (presence),
        .dq_oe     (dq_oe),
        .dq_in     (dq_in),
        .us_start  (us_start),
        .us_finish (us_finish),
        .dbg_state (dbg_state)
    );

    // Scoreboard state
    logic [15:0] exp_low_q[$];
    logic [15:0] exp_rel_q[$];
    logic        exp_pres_q[$];
    int          total = 0;
    int          bad = 0;
    int          exp_done = 0;
    int          timeouts = 0;
    logic        pres_model = 1'b0;
    logic        mon_en = 1'b1;
    logic        finish_req = 1'b0;

    // Delay-timer responder
    int   tmr_lat = 64;
    int   tmr_cnt = 0;
    logic tmr_busy = 1'b0;
    int   inject_req = 0;
    int   inject_ack = 0;

    initial begin
        us_finish = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            us_finish = 1'b0;
            if (tmr_busy) begin
                tmr_cnt++;
                if (tmr_cnt >= tmr_lat) begin
                    us_finish = 1'b1;
                    tmr_busy  = 1'b0;
                end
            end else if (us_start === 1'b1) begin
                tmr_busy = 1'b1;
                tmr_cnt  = 0;
            end
            if (inject_req != inject_ack) begin
                inject_ack = inject_req;
                us_finish  = 1'b1;
            end
        end
    end

    // Slave: after the master releases, pulls low for release ticks 20..199
    logic slave_en = 1'b0;
    logic sl_act = 1'b0;
    logic sl_prev_oe = 1'b0;
    int   sl_cnt = 0;

    initial begin
        slave_pull = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (sl_prev_oe && dq_oe === 1'b0) begin
                sl_act = slave_en;
                sl_cnt = 0;
            end
            sl_prev_oe = (dq_oe === 1'b1);
            if (sl_act && us_finish) sl_cnt++;
            slave_pull = sl_act && (sl_cnt >= 20) && (sl_cnt < 200);
            if (sl_cnt >= 200) sl_act = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t state=%0d)", name, act, exp, $time, dbg_state);
        end
    endtask

    // Monitor: samples on the falling edge, pops expectations when the DUT shows a phase edge or done
    int   cyc = 0;
    int   cyc_all = 0;
    int   low_cnt = 0;
    int   rel_cnt = 0;
    int   done_cnt = 0;
    logic in_rel = 1'b0;
    logic oe_prev = 1'b0;
    logic rst_prev = 1'b0;
    logic mon_out = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc_all++;
            if (cyc_all > 95000) begin
                check("watchdog", cyc_all, 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (us_finish) mon_out = 1'b0;
            if (us_start === 1'b1) begin
                check("start_while_outstanding", mon_out, 0);
                mon_out = 1'b1;
            end
            if (reset) begin
                if (rst_prev) begin
                    check("rst_dq_oe", dq_oe, 0);
                    check("rst_done", done, 0);
                    check("rst_cmd_ready", cmd_ready, 0);
                    check("rst_us_start", us_start, 0);
                    check("rst_presence", presence, 0);
                end
                cyc = 0;
                low_cnt = 0;
                rel_cnt = 0;
                in_rel = 1'b0;
            end else begin
                cyc++;
                if (cyc <= 80) begin
                    check("drain_cmd_ready", cmd_ready, 0);
                    check("drain_us_start", us_start, 0);
                end
                if (cyc == 81) check("ready_after_drain", cmd_ready, 1);
                if (!mon_en && done) check("done_after_abort", done, 0);
                if (mon_en) begin
                    if (!oe_prev && dq_oe) begin
                        if (in_rel) begin
                            check("rel_q_nonempty", exp_rel_q.size() != 0, 1);
                            if (exp_rel_q.size() != 0) check("rel_ticks", rel_cnt, exp_rel_q.pop_front());
                        end
                        low_cnt = 0;
                        in_rel = 1'b0;
                    end
                    if (oe_prev && !dq_oe) begin
                        check("low_q_nonempty", exp_low_q.size() != 0, 1);
                        if (exp_low_q.size() != 0) check("low_ticks", low_cnt, exp_low_q.pop_front());
                        rel_cnt = 0;
                        in_rel = 1'b1;
                    end
                    if (done) begin
                        done_cnt++;
                        check("rel_q_nonempty_done", exp_rel_q.size() != 0, 1);
                        if (exp_rel_q.size() != 0) check("rel_ticks_last", rel_cnt, exp_rel_q.pop_front());
                        check("pres_q_nonempty", exp_pres_q.size() != 0, 1);
                        if (exp_pres_q.size() != 0) check("presence", presence, exp_pres_q.pop_front());
                        in_rel = 1'b0;
                    end
                    if (us_finish) begin
                        if (dq_oe) low_cnt++;
                        else if (in_rel) rel_cnt++;
                    end
                end
            end
            rst_prev = reset;
            oe_prev = (dq_oe === 1'b1);
            if (finish_req) begin
                check("low_q_drained", exp_low_q.size(), 0);
                check("rel_q_drained", exp_rel_q.size(), 0);
                check("pres_q_drained", exp_pres_q.size(), 0);
                check("done_count", done_cnt, exp_done);
                check("stimulus_timeouts", timeouts, 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    // Driver tasks
    task automatic exp_reset(input logic pres);
        exp_low_q.push_back(16'd400);
        exp_rel_q.push_back(16'd400);
        pres_model = pres;
        exp_pres_q.push_back(pres);
        exp_done++;
    endtask

    // Write slot: low 5 (bit 1) or 50 (bit 0); released for the rest of 55 plus 2 recovery.
    task automatic exp_write(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            exp_low_q.push_back(d[i] ? 16'd5 : 16'd50);
            exp_rel_q.push_back(d[i] ? 16'd52 : 16'd7);
        end
        exp_pres_q.push_back(pres_model);
        exp_done++;
    endtask

    task automatic send(input logic rst_cmd, input logic [7:0] d, input logic hold);
        int n;
        n = 0;
        cmd_reset = rst_cmd;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeouts++;
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_reset = 1'b1;
            cmd_data  = 8'h00;
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) timeouts++;
    endtask

    task automatic wait_oe(input logic lvl, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dq_oe !== lvl && n < budget);
        if (dq_oe !== lvl) timeouts++;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeouts++;
    endtask

    // Stimulus
    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_reset = 1'b0;
        cmd_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // stale finish during drain
        repeat (10) @(posedge clk);
        #2 inject_req++;
        wait_ready(200);
        tmr_lat = 12;

        // reset sequence with a responding slave
        slave_en = 1'b1;
        exp_reset(1'b1);
        send(1'b1, 8'h00, 1'b0);
        wait_done(40000);
        slave_en = 1'b0;

        // byte write with a second request held during the whole write
        exp_write(8'hA5);
        send(1'b0, 8'hA5, 1'b1);
        wait_done(40000);
        cmd_valid = 1'b0;

        // reset sequence, nobody answers
        exp_reset(1'b0);
        send(1'b1, 8'h00, 1'b0);
        wait_done(40000);

        // back-to-back writes
        exp_write(8'h00);
        exp_write(8'hFF);
        send(1'b0, 8'h00, 1'b0);
        wait_done(40000);
        send(1'b0, 8'hFF, 1'b0);
        wait_done(40000);

        // abort a write during bit 3 with the full 64-cycle timer latency
        tmr_lat = 64;
        mon_en = 1'b0;
        send(1'b0, 8'h5A, 1'b0);
        repeat (3) begin
            wait_oe(1'b0, 20000);
            wait_oe(1'b1, 20000);
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        wait_ready(200);
        tmr_lat = 12;

        // next command after the abort
        exp_write(8'h3C);
        send(1'b0, 8'h3C, 1'b0);
        wait_done(40000);

        repeat (5) @(negedge clk);
        finish_req = 1'b1;
    end

endmodule
